// File: rtl/pwm_pkg.sv
// Shared register map, bit positions and bus widths for the multi-channel Wishbone PWM.
package pwm_pkg;
    localparam int unsigned WB_AW      = 32;
    localparam int unsigned WB_DW      = 32;
    localparam int unsigned WB_SW      = 4;
    localparam int unsigned ADR_W      = 5;
    localparam int unsigned PRESCALE_W = 16;

    localparam logic [ADR_W-1:0] ADR_CTRL     = 5'd0;
    localparam logic [ADR_W-1:0] ADR_PERIOD   = 5'd1;
    localparam logic [ADR_W-1:0] ADR_PRESCALE = 5'd2;
    localparam logic [ADR_W-1:0] ADR_STATUS   = 5'd3;
    localparam logic [ADR_W-1:0] ADR_DUTY0    = 5'd4;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_CENTER = 1;
    localparam int unsigned CTRL_IE     = 2;
    localparam int unsigned STATUS_PEND = 0;

    // Field order matches the CTRL bit positions above (en is bit 0).
    typedef struct packed {
        logic ie;
        logic center;
        logic en;
    } ctrl_t;
endpackage

// File: rtl/wb_pwm_mc_if.sv
// Wishbone slave bundle for the PWM block.
interface wb_pwm_mc_if;
    import pwm_pkg::*;

    logic             wb_stb_i;
    logic             wb_cyc_i;
    logic             wb_we_i;
    logic [WB_AW-1:0] wb_adr_i;
    logic [WB_SW-1:0] wb_sel_i;
    logic [WB_DW-1:0] wb_dat_i;
    logic [WB_DW-1:0] wb_dat_o;
    logic             wb_ack_o;

    modport slave  (input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
                    output wb_dat_o, wb_ack_o);
    modport master (output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
                    input  wb_dat_o, wb_ack_o);
endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus edge/center-aligned period counter; flags each period boundary.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned RES = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  center,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [RES-1:0]        period,
    output logic [RES-1:0]        cnt,
    output logic                  boundary
);
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [RES-1:0]        cnt_q, cnt_d;
    logic                  down_q, down_d;

    always_comb begin
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        down_d   = down_q;
        boundary = 1'b0;
        if (!en || restart) begin
            presc_d = '0;
            cnt_d   = '0;
            down_d  = 1'b0;
        end else if (presc_q >= prescale) begin
            presc_d = '0;
            if (!center) begin
                if (cnt_q >= period) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + RES'(1);
                end
            end else if (!down_q && cnt_q < period) begin
                cnt_d = cnt_q + RES'(1);
            end else begin
                // Turning at the top skips a repeat of PERIOD; landing on 0 ends the period.
                cnt_d  = cnt_q - RES'(1);
                down_d = 1'b1;
                if (cnt_q <= RES'(1)) begin
                    cnt_d    = '0;
                    down_d   = 1'b0;
                    boundary = 1'b1;
                end
            end
        end else begin
            presc_d = presc_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            down_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            down_q  <= down_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/wb_pwm_mc.sv
// Multi-channel PWM with Wishbone register file and period-boundary shadowed duty/period.
module wb_pwm_mc
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned RES      = 9
) (
    input  logic                clk,
    input  logic                rst,
    wb_pwm_mc_if.slave          wb,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                irq
);
    logic                  ack_q, ack_d;
    logic [WB_DW-1:0]      dat_q, dat_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [RES-1:0]        period_q, period_d, period_sh_q, period_sh_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  pend_q, pend_d;
    logic                  irq_q, irq_d;
    logic [RES-1:0]        duty_all [CHANNELS];
    logic [WB_DW-1:0]      rdata_c;
    logic [RES-1:0]        cnt;
    logic                  boundary;
    logic                  req_c, wr_c, restart_c, w1c_c, load_c;
    logic [ADR_W-1:0]      adr_c;
    logic                  unused_bits;

    assign adr_c     = wb.wb_adr_i[ADR_W+1:2];
    assign req_c     = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
    assign wr_c      = req_c & wb.wb_we_i;
    assign restart_c = wr_c && adr_c == ADR_CTRL && wb.wb_dat_i[CTRL_CENTER] != ctrl_q.center;
    assign w1c_c     = wr_c && adr_c == ADR_STATUS && wb.wb_dat_i[STATUS_PEND];
    assign load_c    = !ctrl_q.en || boundary;

    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[WB_AW-1:ADR_W+2], wb.wb_adr_i[1:0],
                           wb.wb_dat_i[WB_DW-1:PRESCALE_W]};

    pwm_timebase #(.RES(RES)) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_q.en),
        .center   (ctrl_q.center),
        .restart  (restart_c),
        .prescale (prescale_q),
        .period   (period_sh_q),
        .cnt      (cnt),
        .boundary (boundary)
    );

    // Read mux: DUTY reads return the pending register, not the shadow.
    always_comb begin
        rdata_c = '0;
        case (adr_c)
            ADR_CTRL:     rdata_c = WB_DW'(ctrl_q);
            ADR_PERIOD:   rdata_c = WB_DW'(period_q);
            ADR_PRESCALE: rdata_c = WB_DW'(prescale_q);
            ADR_STATUS:   rdata_c[STATUS_PEND] = pend_q;
            default: begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    if (adr_c == ADR_W'(ADR_DUTY0 + ADR_W'(i))) rdata_c = WB_DW'(duty_all[i]);
                end
            end
        endcase
    end

    always_comb begin
        ack_d      = req_c;
        dat_d      = dat_q;
        ctrl_d     = ctrl_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        if (req_c && !wb.wb_we_i) dat_d = rdata_c;
        if (wr_c) begin
            case (adr_c)
                ADR_CTRL: begin
                    ctrl_d.en     = wb.wb_dat_i[CTRL_EN];
                    ctrl_d.center = wb.wb_dat_i[CTRL_CENTER];
                    ctrl_d.ie     = wb.wb_dat_i[CTRL_IE];
                end
                ADR_PERIOD:   period_d   = wb.wb_dat_i[RES-1:0];
                ADR_PRESCALE: prescale_d = wb.wb_dat_i[PRESCALE_W-1:0];
                default:      ;
            endcase
        end
        // A boundary wins over a coincident clear so no period end is lost.
        pend_d      = boundary | (pend_q & ~w1c_c);
        irq_d       = pend_d & ctrl_d.ie;
        period_sh_d = load_c ? period_q : period_sh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            ctrl_q      <= '0;
            period_q    <= '0;
            period_sh_q <= '0;
            prescale_q  <= '0;
            pend_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            ctrl_q      <= ctrl_d;
            period_q    <= period_d;
            period_sh_q <= period_sh_d;
            prescale_q  <= prescale_d;
            pend_q      <= pend_d;
            irq_q       <= irq_d;
        end
    end

    for (genvar gi = 0; gi < int'(CHANNELS); gi++) begin : g_ch
        logic [RES-1:0] duty_q, duty_d, shadow_q, shadow_d;
        logic           pwm_q, pwm_d;

        always_comb begin
            duty_d = duty_q;
            if (wr_c && adr_c == ADR_W'(ADR_DUTY0 + ADR_W'(gi))) duty_d = wb.wb_dat_i[RES-1:0];
            shadow_d = load_c ? duty_q : shadow_q;
            pwm_d    = ctrl_q.en && (cnt < shadow_q);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                duty_q   <= '0;
                shadow_q <= '0;
                pwm_q    <= 1'b0;
            end else begin
                duty_q   <= duty_d;
                shadow_q <= shadow_d;
                pwm_q    <= pwm_d;
            end
        end

        assign duty_all[gi] = duty_q;
        assign pwm_out[gi]  = pwm_q;
    end

    assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack_q;
    assign wb.wb_dat_o = dat_q;
    assign irq         = irq_q;
endmodule
